// File: rtl/shared_adder_arbiter.sv
// Two-requester 64-bit adder built around one SEG_W-bit carry-select segment.
// A round-robin arbiter picks one requester. The FSM then walks the operands
// one segment per cycle. The finished sum and carry are published as a
// one-cycle result pulse.
//
// Handshake (both requesters): a requester raises valid_i and holds it, with
// stable operands, until it sees ready_o. A transfer happens in exactly the
// cycle where valid_i && ready_o. ready_o is combinational and is only ever
// high in IDLE, for the granted requester, while that requester's valid_i is
// high and reset is low. Operands are sampled only on the transfer cycle.
// Dropping valid_i before the transfer withdraws the request silently.
module shared_adder_arbiter #(
   parameter int SEG_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   input  logic [63:0] req0_a_i,
   input  logic [63:0] req0_b_i,
   output logic        req0_ready_o,
   input  logic        req1_valid_i,
   input  logic [63:0] req1_a_i,
   input  logic [63:0] req1_b_i,
   output logic        req1_ready_o,
   output logic        res_valid_o,
   output logic        res_id_o,
   output logic [63:0] sum_o,
   output logic        carry_o,
   output logic        busy_o
);

   localparam int NSEG  = 64 / SEG_W;
   localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // FSM and arbitration state
   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;

   // Latched operation: operands, owner, segment walk and working sum
   logic [63:0]      a_q, a_d;
   logic [63:0]      b_q, b_d;
   logic             id_q, id_d;
   logic [IDX_W-1:0] seg_idx_q, seg_idx_d;
   logic             seg_carry_q, seg_carry_d;
   logic [63:0]      work_q, work_d;

   // Published result. It only changes on entry to DONE, so requesters can
   // read the previous result for the whole duration of the next operation.
   logic [63:0]      sum_q, sum_d;
   logic             res_carry_q, res_carry_d;
   logic             res_id_q, res_id_d;

   // Combinational helpers
   logic             grant;
   logic             xfer;
   logic [6:0]       seg_lo;
   logic [SEG_W-1:0] seg_a;
   logic [SEG_W-1:0] seg_b;
   logic [SEG_W:0]   seg_sum_c0;
   logic [SEG_W:0]   seg_sum_c1;
   logic [SEG_W:0]   seg_sum_sel;

   // Round-robin choice: under contention, serve whoever did not win last time.
   always_comb begin
      grant = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         grant = ~last_grant_q;
      end else if (req1_valid_i) begin
         grant = 1'b1;
      end
   end

   // Ready is offered only in IDLE and never while reset is asserted.
   always_comb begin
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      if ((state_q == IDLE) && !rst_i) begin
         req0_ready_o = req0_valid_i && !grant;
         req1_ready_o = req1_valid_i && grant;
      end
      xfer = req0_ready_o | req1_ready_o;
   end

   // Shared segment: precompute both carry-in cases, then pick one with the
   // registered carry from the previous segment.
   always_comb begin
      seg_lo      = 7'(seg_idx_q) * 7'(SEG_W);
      seg_a       = a_q[seg_lo +: SEG_W];
      seg_b       = b_q[seg_lo +: SEG_W];
      seg_sum_c0  = {1'b0, seg_a} + {1'b0, seg_b};
      seg_sum_c1  = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, 1'b1};
      seg_sum_sel = seg_carry_q ? seg_sum_c1 : seg_sum_c0;
   end

   // Next-state logic: capture on transfer, one segment per CALC cycle,
   // publish when the last segment finishes, then a single DONE cycle.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      seg_idx_d    = seg_idx_q;
      seg_carry_d  = seg_carry_q;
      work_d       = work_q;
      sum_d        = sum_q;
      res_carry_d  = res_carry_q;
      res_id_d     = res_id_q;

      case (state_q)
         IDLE: begin
            if (xfer) begin
               a_d          = grant ? req1_a_i : req0_a_i;
               b_d          = grant ? req1_b_i : req0_b_i;
               id_d         = grant;
               last_grant_d = grant;
               seg_idx_d    = '0;
               seg_carry_d  = 1'b0;
               work_d       = '0;
               state_d      = CALC;
            end
         end
         CALC: begin
            work_d[seg_lo +: SEG_W] = seg_sum_sel[SEG_W-1:0];
            seg_carry_d             = seg_sum_sel[SEG_W];
            if (seg_idx_q == LAST_IDX) begin
               sum_d       = work_d;
               res_carry_d = seg_sum_sel[SEG_W];
               res_id_d    = id_q;
               state_d     = DONE;
            end else begin
               seg_idx_d = seg_idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset aborts any operation in flight and clears the
   // published result. last_grant resets to 1 so requester 0 wins the first
   // contention.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         seg_idx_q    <= '0;
         seg_carry_q  <= 1'b0;
         work_q       <= '0;
         sum_q        <= '0;
         res_carry_q  <= 1'b0;
         res_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         seg_idx_q    <= seg_idx_d;
         seg_carry_q  <= seg_carry_d;
         work_q       <= work_d;
         sum_q        <= sum_d;
         res_carry_q  <= res_carry_d;
         res_id_q     <= res_id_d;
      end
   end

   // Result pulse is suppressed in a reset cycle, so an aborted operation
   // never reports.
   assign res_valid_o = (state_q == DONE) && !rst_i;
   assign busy_o      = (state_q != IDLE);
   assign sum_o       = sum_q;
   assign carry_o     = res_carry_q;
   assign res_id_o    = res_id_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Bench for shared_adder_arbiter: per-cycle model comparison on the default
// build, directed scenarios with literal expectations, and a random operand
// sweep on SEG_W=8 and SEG_W=64 builds.
`timescale 1ns/1ps
module tb_shared_adder_arbiter;

   localparam int NSEG = 4;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i;
   logic        req0_valid_i, req1_valid_i;
   logic [63:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic        req0_ready_o, req1_ready_o;
   logic        res_valid_o, res_id_o, carry_o, busy_o;
   logic [63:0] sum_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   shared_adder_arbiter #(.SEG_W(16)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
      .req0_ready_o(req0_ready_o),
      .req1_valid_i(req1_valid_i), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
      .req1_ready_o(req1_ready_o),
      .res_valid_o(res_valid_o), .res_id_o(res_id_o), .sum_o(sum_o),
      .carry_o(carry_o), .busy_o(busy_o)
   );

   // sweep builds: index 0 is SEG_W=8, index 1 is SEG_W=64
   logic        sw_valid[2];
   logic [63:0] sw_a[2], sw_b[2];
   logic        sw_ready[2], sw_res_valid[2], sw_carry[2];
   logic [63:0] sw_sum[2];
   logic        sw_nc_ready1[2], sw_nc_id[2], sw_nc_busy[2];

   shared_adder_arbiter #(.SEG_W(8)) dut8 (
      .clk_i(clk), .rst_i(rst_i),
      .req0_valid_i(sw_valid[0]), .req0_a_i(sw_a[0]), .req0_b_i(sw_b[0]),
      .req0_ready_o(sw_ready[0]),
      .req1_valid_i(1'b0), .req1_a_i(64'd0), .req1_b_i(64'd0),
      .req1_ready_o(sw_nc_ready1[0]),
      .res_valid_o(sw_res_valid[0]), .res_id_o(sw_nc_id[0]), .sum_o(sw_sum[0]),
      .carry_o(sw_carry[0]), .busy_o(sw_nc_busy[0])
   );

   shared_adder_arbiter #(.SEG_W(64)) dut64 (
      .clk_i(clk), .rst_i(rst_i),
      .req0_valid_i(sw_valid[1]), .req0_a_i(sw_a[1]), .req0_b_i(sw_b[1]),
      .req0_ready_o(sw_ready[1]),
      .req1_valid_i(1'b0), .req1_a_i(64'd0), .req1_b_i(64'd0),
      .req1_ready_o(sw_nc_ready1[1]),
      .res_valid_o(sw_res_valid[1]), .res_id_o(sw_nc_id[1]), .sum_o(sw_sum[1]),
      .carry_o(sw_carry[1]), .busy_o(sw_nc_busy[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the default build. It tracks only how many cycles
   // remain in the current operation, who won last, and the published result.
   int          m_left  = 0;
   bit          m_last  = 1'b1;
   logic [63:0] m_sum   = 64'd0;
   bit          m_carry = 1'b0;
   bit          m_id    = 1'b0;
   logic [63:0] m_a     = 64'd0;
   logic [63:0] m_b     = 64'd0;
   bit          m_op_id = 1'b0;

   // Compare process: inputs are stable from posedge+1 to the next posedge,
   // so check at negedge, then advance the model across the coming edge.
   always @(negedge clk) begin : model_blk
      bit          g, e_r0, e_r1;
      logic [64:0] full;
      if (chk_en) begin
         g    = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
         e_r0 = !rst_i && (m_left == 0) && req0_valid_i && !g;
         e_r1 = !rst_i && (m_left == 0) && req1_valid_i && g;
         check("m_ready0", req0_ready_o, e_r0);
         check("m_ready1", req1_ready_o, e_r1);
         check("m_busy", busy_o, m_left != 0);
         check("m_res_valid", res_valid_o, (m_left == 1) && !rst_i);
         check("m_sum", sum_o, m_sum);
         check("m_carry", carry_o, m_carry);
         check("m_res_id", res_id_o, m_id);
         if (rst_i) begin
            m_left = 0; m_last = 1'b1; m_sum = 64'd0; m_carry = 1'b0; m_id = 1'b0;
         end else if (m_left == 0) begin
            if (e_r0 || e_r1) begin
               m_left  = NSEG + 1;
               m_a     = g ? req1_a_i : req0_a_i;
               m_b     = g ? req1_b_i : req0_b_i;
               m_op_id = g;
               m_last  = g;
            end
         end else begin
            m_left--;
            if (m_left == 1) begin
               full    = {1'b0, m_a} + {1'b0, m_b};
               m_sum   = full[63:0];
               m_carry = full[64];
               m_id    = m_op_id;
            end
         end
      end
   end

   // driver tasks
   task automatic set_req(input bit id, input bit v, input logic [63:0] a, input logic [63:0] b);
      if (id) begin
         req1_valid_i = v; req1_a_i = a; req1_b_i = b;
      end else begin
         req0_valid_i = v; req0_a_i = a; req0_b_i = b;
      end
   endtask

   // Wait up to 'budget' cycles for a result pulse and return its latency (0 = none).
   task automatic wait_result(input int budget, output int lat);
      lat = 0;
      for (int i = 1; i <= budget && lat == 0; i++) begin
         @(negedge clk);
         if (res_valid_o) lat = i;
      end
   endtask

   task automatic single_op(input bit id, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp_sum, input bit exp_carry, input string tag);
      bit got;
      int lat;
      got = 1'b0;
      @(posedge clk); #1;
      set_req(id, 1'b1, a, b);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (id ? req1_ready_o : req0_ready_o) got = 1'b1;
      end
      check({tag, "_accepted"}, got, 1'b1);
      @(posedge clk); #1;
      set_req(id, 1'b0, 64'd0, 64'd0);
      wait_result(10, lat);
      check({tag, "_latency"}, lat, 5);
      check({tag, "_sum"}, sum_o, exp_sum);
      check({tag, "_carry"}, carry_o, exp_carry);
      check({tag, "_id"}, res_id_o, id);
   endtask

   task automatic contention();
      int          ids[$];
      int          cyc_q[$];
      logic [63:0] sums[$];
      @(posedge clk); #1;
      rst_i = 1'b1;
      set_req(0, 1'b1, 64'd1, 64'd2);
      set_req(1, 1'b1, 64'd10, 64'd20);
      @(posedge clk); #1;
      rst_i = 1'b0;
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         if (res_valid_o) begin
            ids.push_back(int'(res_id_o));
            cyc_q.push_back(i);
            sums.push_back(sum_o);
         end
      end
      @(posedge clk); #1;
      set_req(0, 1'b0, 64'd0, 64'd0);
      set_req(1, 1'b0, 64'd0, 64'd0);
      repeat (8) @(posedge clk);
      check("cont_count", ids.size(), 4);
      for (int k = 0; k < 4 && k < ids.size(); k++) begin
         check("cont_id", ids[k], k % 2);
         check("cont_sum", sums[k], (k % 2) ? 64'd30 : 64'd3);
         if (k > 0) check("cont_gap", cyc_q[k] - cyc_q[k-1], 6);
      end
   endtask

   task automatic backpressure();
      int lat;
      @(posedge clk); #1; set_req(0, 1'b1, 64'd100, 64'd23);   // T
      @(posedge clk); #1; set_req(0, 1'b0, 64'd0, 64'd0);      // T+1
      @(posedge clk); #1; set_req(1, 1'b1, 64'd5, 64'd6);      // T+2
      @(negedge clk); check("bp_ready1_calc", req1_ready_o, 1'b0);
      @(posedge clk); #1; set_req(1, 1'b1, 64'd7, 64'd8);      // T+3
      @(posedge clk); #1; set_req(1, 1'b1, 64'd9, 64'd10);     // T+4
      @(negedge clk); check("bp_ready1_calc2", req1_ready_o, 1'b0);
      @(negedge clk);                                          // T+5 DONE
      check("bp_ready1_done", req1_ready_o, 1'b0);
      check("bp_res0_valid", res_valid_o, 1'b1);
      check("bp_res0_sum", sum_o, 64'd123);
      @(negedge clk); check("bp_ready1_idle", req1_ready_o, 1'b1);   // T+6
      @(posedge clk); #1; set_req(1, 1'b0, 64'd0, 64'd0);
      wait_result(10, lat);
      check("bp_latency", lat, 5);
      check("bp_sum", sum_o, 64'd19);
      check("bp_id", res_id_o, 1'b1);
   endtask

   task automatic cancel_req();
      int pulses;
      pulses = 0;
      @(posedge clk); #1; set_req(0, 1'b1, 64'd1, 64'd1);
      @(posedge clk); #1; set_req(0, 1'b0, 64'd0, 64'd0);
      @(posedge clk); #1; set_req(1, 1'b1, 64'd50, 64'd50);
      @(posedge clk); #1; set_req(1, 1'b0, 64'd0, 64'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (res_valid_o) pulses++;
      end
      check("cancel_pulses", pulses, 1);
      check("cancel_sum", sum_o, 64'd2);
      check("cancel_busy", busy_o, 1'b0);
   endtask

   task automatic reset_mid();
      int lat;
      @(posedge clk); #1; set_req(0, 1'b1, 64'hDEAD, 64'hBEEF);   // T
      @(posedge clk); #1; set_req(0, 1'b0, 64'd0, 64'd0);         // T+1
      @(posedge clk); #1; rst_i = 1'b1;                           // T+2
      @(negedge clk); check("rmid_busy_pre", busy_o, 1'b1);
      @(posedge clk); #1; rst_i = 1'b0;
      @(negedge clk);
      check("rmid_busy", busy_o, 1'b0);
      check("rmid_sum", sum_o, 64'd0);
      check("rmid_carry", carry_o, 1'b0);
      check("rmid_id", res_id_o, 1'b0);
      wait_result(8, lat);
      check("rmid_no_pulse", lat, 0);
      single_op(1'b1, 64'd5, 64'd7, 64'd12, 1'b0, "after_rst");
   endtask

   task automatic sweep(input int k, input int nseg, input int n);
      int          lat;
      logic [63:0] a, b;
      logic [64:0] ref_full;
      string       pfx;
      pfx = (k == 0) ? "sw8" : "sw64";
      for (int t = 0; t < n; t++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (t == 0) begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; end
         ref_full = {1'b0, a} + {1'b0, b};
         @(posedge clk); #1;
         sw_valid[k] = 1'b1; sw_a[k] = a; sw_b[k] = b;
         @(negedge clk); check({pfx, "_ready"}, sw_ready[k], 1'b1);
         @(posedge clk); #1;
         sw_valid[k] = 1'b0;
         lat = 0;
         for (int i = 1; i <= nseg + 4 && lat == 0; i++) begin
            @(negedge clk);
            if (sw_res_valid[k]) lat = i;
         end
         check({pfx, "_latency"}, lat, nseg + 1);
         check({pfx, "_sum"}, sw_sum[k], ref_full[63:0]);
         check({pfx, "_carry"}, sw_carry[k], ref_full[64]);
      end
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      rst_i = 1'b1;
      set_req(0, 1'b0, 64'd0, 64'd0);
      set_req(1, 1'b0, 64'd0, 64'd0);
      for (int k = 0; k < 2; k++) begin
         sw_valid[k] = 1'b0; sw_a[k] = 64'd0; sw_b[k] = 64'd0;
      end
      @(posedge clk); #1; chk_en = 1'b1;
      @(posedge clk); #1; rst_i = 1'b0;
      @(negedge clk);
      check("rst_busy", busy_o, 1'b0);
      check("rst_sum", sum_o, 64'd0);
      check("rst_carry", carry_o, 1'b0);
      check("rst_id", res_id_o, 1'b0);
      check("rst_res_valid", res_valid_o, 1'b0);

      single_op(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0, "single");
      single_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, "overflow");
      single_op(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, "msb_carry");
      single_op(1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "no_carry");
      single_op(1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001,
                64'h0001_0000_0001_0000, 1'b0, "seg_carry");

      contention();
      backpressure();
      cancel_req();
      reset_mid();

      fork
         sweep(0, 8, 1000);
         sweep(1, 1, 1000);
      join

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
